// File: rtl/layer_seq.sv
// Layer sequencer: steps a descriptor table through bias load, weight load and run
// phases, driving the convolution engine's geometry and phase controls.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch descriptor at layer into config outputs and counters
// BIAS  | bwrite high, count bias beats
// WGT   | wwrite high, count weight beats
// GAP   | all phase controls low so sample_ctrl re-initialises
// RUN   | run high, count smp_done pulses
// GAP2  | all phase controls low, advance layer or finish
// FIN   | done pulse, then back to IDLE
module layer_seq #(
  parameter int N_LAYER = 8,
  parameter int LW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_layer,
  input  logic [2:0]    cfg_field,
  input  logic [31:0]   cfg_wdata,
  input  logic [LW-1:0] nlayer,
  input  logic          start,
  input  logic          abort,
  input  logic          src_valid,
  input  logic          src_ready,
  input  logic          smp_done,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] layer,
  output logic          bwrite,
  output logic          wwrite,
  output logic          run,
  output logic          backprop,
  output logic [3:0]    id,
  output logic [3:0]    od,
  output logic [9:0]    is,
  output logic [9:0]    os,
  output logic [4:0]    ih,
  output logic [4:0]    iw,
  output logic [4:0]    oh,
  output logic [4:0]    ow,
  output logic [7:0]    fs,
  output logic [4:0]    ks,
  output logic [2:0]    kh,
  output logic [2:0]    kw,
  output logic [11:0]   ss,
  output logic [11:0]   ds
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_BIAS = 3'd2;
  localparam logic [2:0] S_WGT  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_GAP2 = 3'd6;
  localparam logic [2:0] S_FIN  = 3'd7;

  // only the meaningful bits of each descriptor word are stored
  logic [24:0] tbl_w0 [N_LAYER];
  logic [23:0] tbl_w1 [N_LAYER];
  logic [18:0] tbl_w2 [N_LAYER];
  logic [25:0] tbl_w3 [N_LAYER];
  logic [31:0] tbl_w4 [N_LAYER];

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] beat_cnt;
  logic [7:0]  smp_cnt;
  logic [9:0]  bcnt;
  logic [15:0] wcnt;
  logic [7:0]  scnt;

  logic [24:0] e0;
  logic [23:0] e1;
  logic [18:0] e2;
  logic [25:0] e3;
  logic [31:0] e4;
  logic [9:0]  e_bcnt;
  logic [15:0] e_wcnt;

  logic beat;
  logic bias_last;
  logic wgt_last;
  logic smp_last;

  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      case (cfg_field)
        3'd0:    tbl_w0[cfg_layer] <= cfg_wdata[24:0];
        3'd1:    tbl_w1[cfg_layer] <= cfg_wdata[23:0];
        3'd2:    tbl_w2[cfg_layer] <= cfg_wdata[18:0];
        3'd3:    tbl_w3[cfg_layer] <= cfg_wdata[25:0];
        3'd4:    tbl_w4[cfg_layer] <= cfg_wdata;
        default: ;
      endcase
    end
  end

  assign e0     = tbl_w0[layer];
  assign e1     = tbl_w1[layer];
  assign e2     = tbl_w2[layer];
  assign e3     = tbl_w3[layer];
  assign e4     = tbl_w4[layer];
  assign e_bcnt = e3[9:0];
  assign e_wcnt = e3[25:10];

  always_comb begin
    beat      = src_valid & src_ready;
    bias_last = beat && (beat_cnt == ({6'd0, bcnt} - 16'd1));
    wgt_last  = beat && (beat_cnt == (wcnt - 16'd1));
    smp_last  = smp_done && (smp_cnt == (scnt - 8'd1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        if (e_bcnt != 10'd0)      state_nx = S_BIAS;
        else if (e_wcnt != 16'd0) state_nx = S_WGT;
        else                      state_nx = S_GAP;
      end
      S_BIAS: if (bias_last) state_nx = (wcnt != 16'd0) ? S_WGT : S_GAP;
      S_WGT:  if (wgt_last) state_nx = S_GAP;
      S_GAP:  state_nx = (scnt != 8'd0) ? S_RUN : S_GAP2;
      S_RUN:  if (smp_last) state_nx = S_GAP2;
      // >= keeps layer from running past nlayer even if nlayer is lowered mid-sequence
      S_GAP2: state_nx = (layer >= nlayer) ? S_FIN : S_LOAD;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // phase controls are decoded from the next state so they toggle on the transition edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      layer    <= '0;
      bwrite   <= 1'b0;
      wwrite   <= 1'b0;
      run      <= 1'b0;
      backprop <= 1'b0;
      beat_cnt <= 16'd0;
      smp_cnt  <= 8'd0;
      bcnt     <= 10'd0;
      wcnt     <= 16'd0;
      scnt     <= 8'd0;
      id       <= 4'd0;
      od       <= 4'd0;
      is       <= 10'd0;
      os       <= 10'd0;
      ih       <= 5'd0;
      iw       <= 5'd0;
      oh       <= 5'd0;
      ow       <= 5'd0;
      fs       <= 8'd0;
      ks       <= 5'd0;
      kh       <= 3'd0;
      kw       <= 3'd0;
      ss       <= 12'd0;
      ds       <= 12'd0;
    end else begin
      state  <= state_nx;
      busy   <= (state_nx != S_IDLE) && (state_nx != S_FIN);
      done   <= (state_nx == S_FIN);
      bwrite <= (state_nx == S_BIAS);
      wwrite <= (state_nx == S_WGT);
      run    <= (state_nx == S_RUN);

      if (state_nx != state)
        beat_cnt <= 16'd0;
      else if (beat && (state == S_BIAS || state == S_WGT))
        beat_cnt <= beat_cnt + 16'd1;

      if (state_nx != state)
        smp_cnt <= 8'd0;
      else if (smp_done && state == S_RUN)
        smp_cnt <= smp_cnt + 8'd1;

      if (abort || (state == S_IDLE && start))
        layer <= '0;
      else if (state == S_GAP2 && state_nx == S_LOAD)
        layer <= layer + LW'(1);

      if (abort) begin
        backprop <= 1'b0;
      end else if (state == S_LOAD) begin
        backprop <= e0[24];
        id       <= e0[3:0];
        is       <= e0[13:4];
        ih       <= e0[18:14];
        iw       <= e0[23:19];
        od       <= e1[3:0];
        os       <= e1[13:4];
        oh       <= e1[18:14];
        ow       <= e1[23:19];
        fs       <= e2[7:0];
        ks       <= e2[12:8];
        kh       <= e2[15:13];
        kw       <= e2[18:16];
        bcnt     <= e_bcnt;
        wcnt     <= e_wcnt;
        ss       <= e4[11:0];
        ds       <= e4[23:12];
        scnt     <= e4[31:24];
      end
    end
  end

endmodule

// File: tb/tb_layer_seq.sv
// Bench for layer_seq: hand-computed vector table, directed corner sequences and
// randomized multi-layer runs scored against per-layer beat/sample expectations.
module tb_layer_seq;
  localparam int NL = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n, cfg_we, start, abort, src_valid, src_ready, smp_done;
  logic [LW-1:0] cfg_layer, nlayer, layer;
  logic [2:0]    cfg_field;
  logic [31:0]   cfg_wdata;
  logic          busy, done, bwrite, wwrite, run, backprop;
  logic [3:0]    id, od;
  logic [9:0]    is, os;
  logic [4:0]    ih, iw, oh, ow, ks;
  logic [7:0]    fs;
  logic [2:0]    kh, kw;
  logic [11:0]   ss, ds;

  layer_seq #(.N_LAYER(NL), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_field(cfg_field), .cfg_wdata(cfg_wdata), .nlayer(nlayer),
    .start(start), .abort(abort), .src_valid(src_valid), .src_ready(src_ready),
    .smp_done(smp_done), .busy(busy), .done(done), .layer(layer),
    .bwrite(bwrite), .wwrite(wwrite), .run(run), .backprop(backprop),
    .id(id), .od(od), .is(is), .os(os), .ih(ih), .iw(iw), .oh(oh), .ow(ow),
    .fs(fs), .ks(ks), .kh(kh), .kw(kw), .ss(ss), .ds(ds)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bcnt, wcnt, scnt;
    bit bp;
    logic [3:0] id, od;
    logic [9:0] isz, osz;
    logic [4:0] ih, iw, oh, ow, ks;
    logic [7:0] fs;
    logic [2:0] kh, kw;
    logic [11:0] ss, ds;
  } desc_t;

  typedef struct {
    int bcnt, wcnt, scnt;
    logic [3:0] vpat;
    int sper;
    int e_bw, e_ww, e_run;
  } vec_t;

  desc_t ent [NL];
  vec_t  vt [8];
  int tests = 0;
  int fails = 0;
  int bw_cyc [NL], bw_beats [NL], ww_cyc [NL], ww_beats [NL];
  int run_cyc [NL], run_smp [NL], cfg_err [NL];
  int order [$];
  int done_cnt;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic desc_t mk(input int b, input int w, input int s, input bit bp);
    desc_t d;
    d.bcnt = b; d.wcnt = w; d.scnt = s; d.bp = bp;
    d.id = 4'($urandom);  d.od = 4'($urandom);
    d.isz = 10'($urandom); d.osz = 10'($urandom);
    d.ih = 5'($urandom);  d.iw = 5'($urandom);
    d.oh = 5'($urandom);  d.ow = 5'($urandom);
    d.ks = 5'($urandom);  d.fs = 8'($urandom);
    d.kh = 3'($urandom);  d.kw = 3'($urandom);
    d.ss = 12'($urandom); d.ds = 12'($urandom);
    return d;
  endfunction

  function automatic bit cfg_ok(input int l);
    return (id == ent[l].id) && (od == ent[l].od) && (is == ent[l].isz) &&
           (os == ent[l].osz) && (ih == ent[l].ih) && (iw == ent[l].iw) &&
           (oh == ent[l].oh) && (ow == ent[l].ow) && (fs == ent[l].fs) &&
           (ks == ent[l].ks) && (kh == ent[l].kh) && (kw == ent[l].kw) &&
           (ss == ent[l].ss) && (ds == ent[l].ds) && (backprop == ent[l].bp);
  endfunction

  // descriptor words packed from the field layout; unused bits carry garbage
  task automatic prog(input int l);
    logic [31:0] w [5];
    w[0] = {7'($urandom), ent[l].bp, ent[l].iw, ent[l].ih, ent[l].isz, ent[l].id};
    w[1] = {8'($urandom), ent[l].ow, ent[l].oh, ent[l].osz, ent[l].od};
    w[2] = {13'($urandom), ent[l].kw, ent[l].kh, ent[l].ks, ent[l].fs};
    w[3] = {6'($urandom), 16'(ent[l].wcnt), 10'(ent[l].bcnt)};
    w[4] = {8'(ent[l].scnt), ent[l].ds, ent[l].ss};
    for (int f = 0; f < 6; f++) begin
      @(negedge clk);
      cfg_we = 1'b1; cfg_layer = LW'(l); cfg_field = 3'(f);
      cfg_wdata = (f < 5) ? w[f] : $urandom;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_seq(input int nl, input bit rnd, input logic [3:0] vpat,
                         input int sper, output int lat);
    bit pb, pw, pr;
    int idx, ridx, last_l;
    for (int i = 0; i < NL; i++) begin
      bw_cyc[i] = 0; bw_beats[i] = 0; ww_cyc[i] = 0; ww_beats[i] = 0;
      run_cyc[i] = 0; run_smp[i] = 0; cfg_err[i] = 0;
    end
    order.delete();
    done_cnt = 0; lat = -1; pb = 0; pw = 0; pr = 0; idx = 0; ridx = 0; last_l = -1;
    @(negedge clk);
    nlayer = LW'(nl); start = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      start = 1'b0;
      if ((bwrite && !pb) || (wwrite && !pw)) idx = 0;
      if (run && !pr) ridx = 0;
      if (rnd) begin
        src_valid = 1'($urandom);
        src_ready = ($urandom % 4) != 0;
        smp_done  = ($urandom % 3) == 0;
      end else begin
        src_ready = 1'b1;
        src_valid = (bwrite || wwrite) ? vpat[idx % 4] : 1'b1;
        smp_done  = run ? ((ridx % sper) == sper - 1) : (bwrite || wwrite);
      end
      idx++; ridx++;
      if (busy && int'(layer) != last_l) begin
        order.push_back(int'(layer));
        last_l = int'(layer);
      end
      if (bwrite) begin
        bw_cyc[layer]++;
        if (src_valid && src_ready) bw_beats[layer]++;
      end
      if (wwrite) begin
        ww_cyc[layer]++;
        if (src_valid && src_ready) ww_beats[layer]++;
      end
      if (run) begin
        run_cyc[layer]++;
        if (smp_done) run_smp[layer]++;
      end
      if ((bwrite || wwrite || run) && !cfg_ok(int'(layer))) cfg_err[layer]++;
      pb = bwrite; pw = wwrite; pr = run;
      if (done) begin
        done_cnt++;
        lat = n;
        break;
      end
    end
    if (lat < 0) chk("seq_timeout", 0, 1);
    else repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    src_valid = 1'b0; smp_done = 1'b0;
  endtask

  function automatic bit any_out();
    return |{busy, done, layer, bwrite, wwrite, run, backprop, id, od, is, os,
             ih, iw, oh, ow, fs, ks, kh, kw, ss, ds};
  endfunction

  initial begin
    int lat, cnt, exp_lat;
    string p;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_wdata = '0;
    nlayer = '0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_ready = 1'b0;
    smp_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", any_out(), 0);
    rst_n = 1'b1;

    //        bcnt wcnt scnt vpat    sper bw  ww  run
    vt[0] = '{4,   9,   2,   4'b1111, 1,  4,  9,  2};
    vt[1] = '{4,   9,   2,   4'b0101, 2,  7,  17, 4};
    vt[2] = '{4,   3,   3,   4'b1001, 3,  8,  5,  9};
    vt[3] = '{1,   1,   1,   4'b1111, 1,  1,  1,  1};
    vt[4] = '{0,   5,   1,   4'b1111, 1,  0,  5,  1};
    vt[5] = '{0,   0,   2,   4'b1111, 2,  0,  0,  4};
    vt[6] = '{3,   0,   0,   4'b1111, 1,  3,  0,  0};
    vt[7] = '{0,   0,   0,   4'b1111, 1,  0,  0,  0};

    for (int i = 0; i < 8; i++) begin
      p = $sformatf("vec%0d", i);
      ent[0] = mk(vt[i].bcnt, vt[i].wcnt, vt[i].scnt, 1'(i));
      prog(0);
      run_seq(0, 1'b0, vt[i].vpat, vt[i].sper, lat);
      // LOAD, GAP, GAP2 and FIN each add one cycle around the phases
      exp_lat = vt[i].e_bw + vt[i].e_ww + vt[i].e_run + 4;
      chk({p, "_bw_cyc"}, bw_cyc[0], vt[i].e_bw);
      chk({p, "_bw_beats"}, bw_beats[0], vt[i].bcnt);
      chk({p, "_ww_cyc"}, ww_cyc[0], vt[i].e_ww);
      chk({p, "_ww_beats"}, ww_beats[0], vt[i].wcnt);
      chk({p, "_run_cyc"}, run_cyc[0], vt[i].e_run);
      chk({p, "_run_smp"}, run_smp[0], vt[i].scnt);
      chk({p, "_done_latency"}, lat, exp_lat);
      chk({p, "_done_count"}, done_cnt, 1);
      chk({p, "_cfg_err"}, cfg_err[0], 0);
      chk({p, "_busy_after"}, busy, 0);
      chk({p, "_cfg_hold"}, cfg_ok(0), 1);
    end

    // three layers, middle one has no load phases and backprop set
    ent[0] = mk(2, 2, 1, 1'b0);
    ent[1] = mk(0, 0, 1, 1'b1);
    ent[2] = mk(1, 1, 1, 1'b0);
    for (int l = 0; l < 3; l++) prog(l);
    run_seq(2, 1'b0, 4'b1111, 1, lat);
    chk("three_order_len", order.size(), 3);
    for (int i = 0; i < order.size() && i < 3; i++)
      chk($sformatf("three_order%0d", i), order[i], i);
    chk("three_l1_bw", bw_cyc[1], 0);
    chk("three_l1_ww", ww_cyc[1], 0);
    chk("three_l1_run", run_cyc[1], 1);
    chk("three_l1_cfg", cfg_err[1], 0);
    chk("three_l0_cfg", cfg_err[0], 0);
    chk("three_l2_cfg", cfg_err[2], 0);
    chk("three_latency", lat, 19);
    chk("three_done_count", done_cnt, 1);
    chk("three_layer_hold", layer, 2);

    // abort during WGT after 5 weight beats
    ent[0] = mk(4, 9, 2, 1'b0);
    prog(0);
    @(negedge clk);
    nlayer = '0; start = 1'b1; src_valid = 1'b1; src_ready = 1'b1; smp_done = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200 && cnt < 5; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (wwrite) cnt++;
    end
    chk("abort_reached_wgt", cnt, 5);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wwrite", wwrite, 0);
    chk("abort_busy", busy, 0);
    chk("abort_layer", layer, 0);
    chk("abort_done", done, 0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || wwrite || busy) cnt++;
    end
    chk("abort_stays_idle", cnt, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_load_busy", busy, 1);
    chk("restart_load_bwrite", bwrite, 0);
    @(negedge clk);
    chk("restart_bias", bwrite, 1);
    chk("restart_layer", layer, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    src_valid = 1'b0;

    // start and abort together stay idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("collide_busy", busy, 0);
    chk("collide_bwrite", bwrite, 0);
    @(negedge clk);
    chk("collide_still_idle", busy, 0);

    // table write while busy must be dropped
    ent[0] = mk(4, 9, 2, 1'b0);
    prog(0);
    @(negedge clk);
    nlayer = '0; start = 1'b1; src_valid = 1'b1; src_ready = 1'b1; smp_done = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cfg_we = 1'b1; cfg_layer = '0; cfg_field = 3'd3; cfg_wdata = {6'd0, 16'd1, 10'd1};
    @(negedge clk);
    cfg_we = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      cnt = n;
    end
    chk("busy_write_seq_done", done, 1);
    src_valid = 1'b0; smp_done = 1'b0;
    run_seq(0, 1'b0, 4'b1111, 1, lat);
    chk("busy_write_bw", bw_cyc[0], 4);
    chk("busy_write_ww", ww_cyc[0], 9);

    // reset in the middle of RUN
    ent[0] = mk(2, 2, 3, 1'b1);
    prog(0);
    @(negedge clk);
    start = 1'b1; src_valid = 1'b1; src_ready = 1'b1; smp_done = 1'b0;
    for (int n = 0; n < 100 && !run; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rst_reached_run", run, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_run_outputs", any_out(), 0);
    cnt = 0;
    repeat (6) begin
      smp_done = ~smp_done;
      @(negedge clk);
      if (busy || run || done) cnt++;
    end
    chk("rst_smp_ignored", cnt, 0);
    smp_done = 1'b0; src_valid = 1'b0;

    // randomized multi-layer runs
    for (int it = 0; it < 6; it++) begin
      int nl;
      nl = int'($urandom_range(0, NL - 1));
      for (int l = 0; l <= nl; l++) begin
        ent[l] = mk(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), 1'($urandom));
        prog(l);
      end
      run_seq(nl, 1'b1, 4'b1111, 1, lat);
      p = $sformatf("rnd%0d", it);
      chk({p, "_order_len"}, order.size(), nl + 1);
      exp_lat = 1;
      for (int l = 0; l <= nl; l++) begin
        if (l < order.size()) chk($sformatf("%s_order%0d", p, l), order[l], l);
        chk($sformatf("%s_l%0d_bias_beats", p, l), bw_beats[l], ent[l].bcnt);
        chk($sformatf("%s_l%0d_wgt_beats", p, l), ww_beats[l], ent[l].wcnt);
        chk($sformatf("%s_l%0d_samples", p, l), run_smp[l], ent[l].scnt);
        chk($sformatf("%s_l%0d_cfg", p, l), cfg_err[l], 0);
        exp_lat += bw_cyc[l] + ww_cyc[l] + run_cyc[l] + 3;
      end
      chk({p, "_latency"}, lat, exp_lat);
      chk({p, "_done_count"}, done_cnt, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
